// File: rtl/buzzer_music_sequencer.sv
// Plays 12-bit note words (beats[11:8], tone[7:0]) from a registered-read ROM as a square wave.
// Define BUZZER_MUSIC_LOOP_EN to restart the song from its start address instead of finishing.
//
// state | meaning
// IDLE  | waiting for play_i
// FETCH | ROM read issued at r_addr
// LOAD  | ROM word valid; end marker check or note setup
// PLAY  | tone or rest for beats x BEAT_CYCLES clocks
// DONE  | one-cycle done_o pulse
module buzzer_music_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 12,
  parameter int BEAT_CYCLES = 12500000,
  parameter int TONE_UNIT   = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_i,
  input  logic                  stop_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  buzzer_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BCW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int TUW = (TONE_UNIT > 1) ? $clog2(TONE_UNIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [3:0]            r_beats;
  logic [7:0]            r_tone;
  logic [7:0]            r_tone_cnt;
  logic [BCW-1:0]        r_beat_pre;
  logic [TUW-1:0]        r_unit_cnt;
  logic                  r_buzz;

  logic w_accept;
  logic w_end_marker;
  logic w_beat_wrap;
  logic w_last;
  logic w_addr_max;
  logic w_unit_tc;
  logic w_toggle;
  logic w_repeat;

  assign w_accept     = play_i && !stop_i;
  assign w_end_marker = (rom_data_i[11:8] == 4'd0);
  assign w_beat_wrap  = (r_beat_pre == BCW'(BEAT_CYCLES - 1));
  assign w_last       = w_beat_wrap && (r_beats == 4'd1);
  assign w_addr_max   = &r_addr;
  assign w_unit_tc    = (r_unit_cnt == '0);
  assign w_toggle     = (r_tone != 8'd0) && w_unit_tc && (r_tone_cnt == 8'd0);

`ifdef BUZZER_MUSIC_LOOP_EN
  assign w_repeat = 1'b1;
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD: begin
        if (!w_end_marker) w_next = S_PLAY;
        else               w_next = w_repeat ? S_FETCH : S_DONE;
      end
      S_PLAY: begin
        if (w_last) w_next = (w_addr_max && !w_repeat) ? S_DONE : S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort wins over every transition above
    if (stop_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_start    <= '0;
      r_beats    <= '0;
      r_tone     <= '0;
      r_tone_cnt <= '0;
      r_beat_pre <= '0;
      r_unit_cnt <= '0;
      r_buzz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= start_addr_i;
            r_start <= start_addr_i;
          end
        end
        S_LOAD: begin
          r_beats    <= rom_data_i[11:8];
          r_tone     <= rom_data_i[7:0];
          r_tone_cnt <= rom_data_i[7:0] - 8'd1;
          r_beat_pre <= '0;
          r_unit_cnt <= TUW'(TONE_UNIT - 1);
          r_buzz     <= 1'b0;
          if (w_next == S_FETCH) r_addr <= r_start;
        end
        S_PLAY: begin
          if (w_beat_wrap) begin
            r_beat_pre <= '0;
            r_beats    <= r_beats - 4'd1;
          end else begin
            r_beat_pre <= r_beat_pre + BCW'(1);
          end
          // Half-period = tone units of TONE_UNIT clocks, counted without a multiplier
          if (w_unit_tc) begin
            r_unit_cnt <= TUW'(TONE_UNIT - 1);
            r_tone_cnt <= (r_tone_cnt == 8'd0) ? (r_tone - 8'd1) : (r_tone_cnt - 8'd1);
          end else begin
            r_unit_cnt <= r_unit_cnt - TUW'(1);
          end
          if (w_toggle) r_buzz <= ~r_buzz;
          if (w_next == S_FETCH) r_addr <= w_addr_max ? r_start : (r_addr + ADDR_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

  assign rom_en_o   = (r_state == S_FETCH);
  assign rom_addr_o = r_addr;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign buzzer_o   = (r_state == S_PLAY) && r_buzz;

endmodule

// File: doc/buzzer_music_sequencer.md
Name: buzzer_music_sequencer

Overview:
- Plays a song stored as note words in a block ROM of buzzer music (registered read, 1-cycle latency) and produces a square-wave buzzer drive.
- Sequences the ROM: drives enable and address, decodes each note word, times tone and duration, and advances to the next word.
- Sits between game control (play/stop requests) and the ROM plus buzzer pin.

Parameters:
- ADDR_WIDTH, 16, ROM address width.
- DATA_WIDTH, 12, ROM word width. Fixed at 12: bits [11:8] are the beat count, bits [7:0] are the tone code.
- BEAT_CYCLES, 12500000, clocks per beat (at least 1).
- TONE_UNIT, 100, clocks per tone-code unit of half-period (at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- play_i  in  1  start pulse; sampled only in IDLE.
- stop_i  in  1  abort request; has priority over play_i.
- start_addr_i  in  ADDR_WIDTH  first note address; latched when play_i is accepted.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  ADDR_WIDTH  ROM address.
- rom_data_i  in  DATA_WIDTH  ROM registered read data.
- buzzer_o  out  1  square-wave output.
- busy_o  out  1  high from play acceptance until return to IDLE.
- done_o  out  1  one-cycle pulse on natural song end.

Behaviour:
- Reset values: all outputs 0, state IDLE, address register 0.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE:
  - play_i=1 and stop_i=0 → latch start_addr_i into the address register and the start register; go to FETCH; busy_o=1 from the next cycle.
- FETCH (1 cycle):
  - rom_en_o=1, rom_addr_o = address register. rom_en_o is 0 in every other state.
  - rom_addr_o holds its last value outside FETCH.
- LOAD (1 cycle): rom_data_i is valid.
  - Beat field = 0 → end marker → DONE.
  - Otherwise latch beats and tone, clear all counters, force buzzer_o=0, go to PLAY.
- PLAY:
  - Lasts exactly beats × BEAT_CYCLES cycles.
  - Beat prescaler counts 0..BEAT_CYCLES-1; beats-remaining counter decrements when the prescaler wraps.
  - Tone code 0 = rest: buzzer_o held 0.
  - Tone code ≠ 0: buzzer_o toggles every tone × TONE_UNIT cycles of PLAY, implemented as a TONE_UNIT prescaler feeding an 8-bit tone counter. No multiplier.
  - First toggle occurs at the PLAY cycle numbered tone × TONE_UNIT, counting the first PLAY cycle as 0.
  - On the last PLAY cycle:
    - Address register = all ones (max address) → DONE. No wrap.
    - Otherwise address register +1 → FETCH.
- DONE (1 cycle): done_o=1, buzzer_o=0; next state IDLE; busy_o=0 from the following cycle.
- stop_i=1 in any non-IDLE state → next cycle IDLE, buzzer_o=0, busy_o=0, rom_en_o=0, no done_o.
- play_i while busy_o=1: ignored.
- play_i and stop_i together in IDLE: stays IDLE.
- rst mid-song: all outputs return to reset values on the next edge.
- Back-to-back notes: 2-cycle FETCH/LOAD gap with buzzer_o=0.

Optional Feature:
- Macro: BUZZER_MUSIC_LOOP_EN.
- Defined: an end marker or max-address completion reloads the address register from the latched start register and goes to FETCH. No DONE, no done_o; busy_o stays 1 until stop_i or rst.
- Undefined: behaviour exactly as above; the song plays once.

Test Plan:
- Basic note (BEAT_CYCLES=8, TONE_UNIT=2; ROM[0]=0x203, ROM[1]=0x000; play_i at cycle T, start_addr_i=0):
  - rom_en_o=1 with addr 0 at T+1.
  - PLAY T+3..T+18; buzzer_o toggles at T+9 and T+15.
  - rom_en_o with addr 1 at T+19; done_o=1 at T+21; busy_o=0 from T+22.
- Rest note (ROM[0]=0x100, ROM[1]=0x000): buzzer_o=0 through all 8 PLAY cycles; done_o pulses once.
- Stop mid-note: stop_i at T+6 of the basic-note case → T+7 buzzer_o=0, busy_o=0; done_o never asserted; later play_i restarts from the new start_addr_i.
- Collisions:
  - play_i again at T+5 → ignored; song timing unchanged.
  - play_i and stop_i together in IDLE → busy_o stays 0.
- Max address (ADDR_WIDTH=2, all words 0x101, start 0): four 8-cycle notes at addresses 0..3, then done_o, no fetch of address 0. With BUZZER_MUSIC_LOOP_EN: FETCH at address 0 again, busy_o stays 1.
- Reset mid-PLAY: rst at T+10 → next cycle all outputs 0, state IDLE; a new play_i behaves as in the basic-note case.
